// File: rtl/xpb_table_gen.sv
// xpb_table_gen
// Generates the XPB lookup table entry[k] = (k * base_r) mod M for
// k = 0 .. NUM-1 by repeated modular addition. One entry costs three
// cycles (WR -> ADD -> RED), so a full table takes 3*NUM-1 cycles from
// the start sample up to and including the done pulse.
module xpb_table_gen #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] modulus,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_ADD  = 3'd2;
    localparam logic [2:0] S_RED  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] mod_q, mod_d;
    logic [DATA_W-1:0] base_r_q, base_r_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W:0]   sum_q, sum_d;

    // Single conditional subtraction: x - m if x >= m, else x. The compare
    // is done on the full DATA_W+1-bit value, so a carry out of DATA_W bits
    // always forces the subtraction. The result is truncated to DATA_W,
    // which also gives the plain mod 2^DATA_W behaviour when m == 0.
    function automatic logic [DATA_W-1:0] cond_sub(
        input logic [DATA_W:0]   x,
        input logic [DATA_W-1:0] m
    );
        logic [DATA_W:0] m_ext;
        logic [DATA_W:0] diff;
        m_ext = {1'b0, m};
        diff  = x - m_ext;
        if (x >= m_ext) begin
            return diff[DATA_W-1:0];
        end
        return x[DATA_W-1:0];
    endfunction

    // Next-state and datapath update for the WR/ADD/RED entry loop.
    always_comb begin
        state_d  = state_q;
        mod_d    = mod_q;
        base_r_d = base_r_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // base is assumed < 2M, so one subtraction fully reduces it
                    mod_d    = modulus;
                    base_r_d = cond_sub({1'b0, base}, modulus);
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                state_d = (idx_q == IDX_LAST) ? S_DONE : S_ADD;
            end
            S_ADD: begin
                sum_d   = {1'b0, acc_q} + {1'b0, base_r_q};
                state_d = S_RED;
            end
            S_RED: begin
                acc_d   = cond_sub(sum_q, mod_q);
                idx_d   = idx_q + IDX_ONE;
                state_d = S_WR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and latched operands; reset clears everything so the
    // write port reads as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mod_q    <= '0;
            base_r_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_d;
            base_r_q <= base_r_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

    // Intermediate sum between ADD and RED; only read in RED, after ADD
    // has always written it, so it needs no reset.
    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign wr_en   = (state_q == S_WR);
    assign wr_addr = idx_q;
    assign wr_data = acc_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: 16-bit, 8-bit and default-width
// instances, cycle-exact checks of write timing, data, done and busy.
module tb_xpb_table_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // 16-bit instance
    logic        s16;
    logic [15:0] b16, m16, wd16;
    logic        busy16, done16, we16;
    logic [4:0]  wa16;

    // 8-bit instance
    logic        s8;
    logic [7:0]  b8, m8, wd8;
    logic        busy8, done8, we8;
    logic [4:0]  wa8;

    // default-width instance
    logic          s1k;
    logic [1023:0] b1k, m1k, wd1k;
    logic          busy1k, done1k, we1k;
    logic [4:0]    wa1k;

    xpb_table_gen #(.DATA_W(16), .IDX_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .base(b16), .modulus(m16),
        .busy(busy16), .done(done16), .wr_en(we16), .wr_addr(wa16), .wr_data(wd16)
    );

    xpb_table_gen #(.DATA_W(8), .IDX_W(5)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .base(b8), .modulus(m8),
        .busy(busy8), .done(done8), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8)
    );

    xpb_table_gen u1k (
        .clk(clk), .rst_n(rst_n), .start(s1k), .base(b1k), .modulus(m1k),
        .busy(busy1k), .done(done1k), .wr_en(we1k), .wr_addr(wa1k), .wr_data(wd1k)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        s16 = 1'b0; b16 = '0; m16 = '0;
        s8  = 1'b0; b8  = '0; m8  = '0;
        s1k = 1'b0; b1k = '0; m1k = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy16, done16, we16, wa16, wd16} !== 24'h0) begin
            errors++;
            $display("FAIL reset16 got %h want 0", {busy16, done16, we16, wa16, wd16});
        end
        checks++;
        if ({busy8, done8, we8, wa8, wd8} !== 16'h0) begin
            errors++;
            $display("FAIL reset8 got %h want 0", {busy8, done8, we8, wa8, wd8});
        end
        checks++;
        if ({busy1k, done1k, we1k, wa1k} !== 8'h0 || wd1k !== '0) begin
            errors++;
            $display("FAIL reset1k ctl=%h data_lo=%h want 0", {busy1k, done1k, we1k, wa1k}, wd1k[127:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Basic, base pre-reduction and zero-modulus sequences on the 16-bit unit
    task automatic test_seq16();
        int tb_base[3] = '{40, 100, 40000};
        int tb_mod[3]  = '{97, 97, 0};
        int br, mm, k, expd;
        logic exp_we;
        for (int t = 0; t < 3; t++) begin
            mm  = tb_mod[t];
            br  = (tb_base[t] >= mm) ? tb_base[t] - mm : tb_base[t];
            b16 = 16'(tb_base[t]);
            m16 = 16'(mm);
            @(posedge clk); #1; s16 = 1'b1;
            @(posedge clk); #1; s16 = 1'b0;
            for (int c = 1; c <= 96; c++) begin
                exp_we = ((c % 3) == 1) && (c <= 94);
                checks++;
                if (we16 !== exp_we) begin
                    errors++;
                    $display("FAIL seq16[%0d] wr_en c=%0d got %b want %b", t, c, we16, exp_we);
                end
                if (exp_we) begin
                    k    = (c - 1) / 3;
                    expd = (mm == 0) ? ((k * br) % 65536) : ((k * br) % mm);
                    checks++;
                    if (wa16 !== 5'(k)) begin
                        errors++;
                        $display("FAIL seq16[%0d] wr_addr c=%0d got %0d want %0d", t, c, wa16, k);
                    end
                    checks++;
                    if (wd16 !== 16'(expd)) begin
                        errors++;
                        $display("FAIL seq16[%0d] wr_data k=%0d got %0d want %0d", t, k, wd16, expd);
                    end
                end
                checks++;
                if (done16 !== (c == 95)) begin
                    errors++;
                    $display("FAIL seq16[%0d] done c=%0d got %b want %b", t, c, done16, (c == 95));
                end
                checks++;
                if (busy16 !== (c <= 95)) begin
                    errors++;
                    $display("FAIL seq16[%0d] busy c=%0d got %b want %b", t, c, busy16, (c <= 95));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // Carry out of 8 bits: 250 + 250 = 500 needs the 9th sum bit
    task automatic test_carry();
        int k, expd;
        logic exp_we;
        b8 = 8'd250; m8 = 8'd251;
        @(posedge clk); #1; s8 = 1'b1;
        @(posedge clk); #1; s8 = 1'b0;
        for (int c = 1; c <= 96; c++) begin
            exp_we = ((c % 3) == 1) && (c <= 94);
            checks++;
            if (we8 !== exp_we) begin
                errors++;
                $display("FAIL carry wr_en c=%0d got %b want %b", c, we8, exp_we);
            end
            if (exp_we) begin
                k    = (c - 1) / 3;
                expd = (k * 250) % 251;
                checks++;
                if (wa8 !== 5'(k) || wd8 !== 8'(expd)) begin
                    errors++;
                    $display("FAIL carry entry c=%0d got (%0d,%0d) want (%0d,%0d)", c, wa8, wd8, k, expd);
                end
            end
            checks++;
            if (done8 !== (c == 95)) begin
                errors++;
                $display("FAIL carry done c=%0d got %b want %b", c, done8, (c == 95));
            end
            @(posedge clk); #1;
        end
    endtask

    // start re-pulsed while busy, operands changed after the sample
    task automatic test_busy_start();
        int nwr, ndone;
        nwr = 0; ndone = 0;
        b16 = 16'd40; m16 = 16'd97;
        @(posedge clk); #1; s16 = 1'b1;
        @(posedge clk); #1; s16 = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            if (c == 10) begin s16 = 1'b1; b16 = 16'd5; m16 = 16'd13; end
            if (c == 11) s16 = 1'b0;
            if (c == 50) s16 = 1'b1;
            if (c == 51) s16 = 1'b0;
            if (we16) begin
                checks++;
                if (wa16 !== 5'(nwr) || wd16 !== 16'((nwr * 40) % 97)) begin
                    errors++;
                    $display("FAIL busy_start entry n=%0d got (%0d,%0d) want (%0d,%0d)",
                             nwr, wa16, wd16, nwr, (nwr * 40) % 97);
                end
                nwr++;
            end
            if (done16) ndone++;
            @(posedge clk); #1;
        end
        checks++;
        if (nwr != 32) begin
            errors++;
            $display("FAIL busy_start writes got %0d want 32", nwr);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_start dones got %0d want 1", ndone);
        end
    endtask

    // Reset mid-generation, then start honoured on first edge after release
    task automatic test_reset_abort();
        int bad;
        b16 = 16'd40; m16 = 16'd97;
        @(posedge clk); #1; s16 = 1'b1;
        @(posedge clk); #1; s16 = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy16, done16, we16, wa16, wd16} !== 24'h0) begin
            errors++;
            $display("FAIL abort outputs got %h want 0", {busy16, done16, we16, wa16, wd16});
        end
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (we16 || done16 || busy16) bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (we16 || done16 || busy16) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort activity got %0d active cycles want 0", bad);
        end
        // start already high when reset releases
        @(negedge clk);
        rst_n = 1'b0;
        s16 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        checks++;
        if (we16 !== 1'b1 || wa16 !== 5'd0 || wd16 !== 16'd0) begin
            errors++;
            $display("FAIL first_edge cycle1 got we=%b (%0d,%0d) want we=1 (0,0)", we16, wa16, wd16);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we16 !== 1'b1 || wa16 !== 5'd1 || wd16 !== 16'd40) begin
            errors++;
            $display("FAIL first_edge cycle4 got we=%b (%0d,%0d) want we=1 (1,40)", we16, wa16, wd16);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    // start held high: restart right after IDLE with no gap write
    task automatic test_back_to_back();
        b16 = 16'd40; m16 = 16'd97;
        @(posedge clk); #1; s16 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 95) begin
                checks++;
                if (done16 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b done c=95 got %b want 1", done16);
                end
            end
            if (c == 96) begin
                checks++;
                if (busy16 !== 1'b0 || we16 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b idle c=96 got busy=%b we=%b want 0 0", busy16, we16);
                end
            end
            if (c == 97) begin
                checks++;
                if (we16 !== 1'b1 || wa16 !== 5'd0 || wd16 !== 16'd0) begin
                    errors++;
                    $display("FAIL b2b restart c=97 got we=%b (%0d,%0d) want we=1 (0,0)", we16, wa16, wd16);
                end
            end
            if (c == 98 || c == 99) begin
                checks++;
                if (we16 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b gap c=%0d got we=%b want 0", c, we16);
                end
            end
            if (c == 100) begin
                checks++;
                if (we16 !== 1'b1 || wa16 !== 5'd1 || wd16 !== 16'd40) begin
                    errors++;
                    $display("FAIL b2b second c=100 got we=%b (%0d,%0d) want we=1 (1,40)", we16, wa16, wd16);
                end
            end
            @(posedge clk); #1;
        end
        s16 = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Default 1024-bit width against a wide multiply-and-modulo golden model
    task automatic test_full_width();
        logic [1029:0] prod;
        logic [1029:0] mext;
        logic [1029:0] rem;
        logic [1023:0] expd;
        logic          exp_we;
        int            k;
        for (int i = 0; i < 32; i++) begin
            m1k[i*32 +: 32] = $urandom;
            b1k[i*32 +: 32] = $urandom;
        end
        m1k[1023] = 1'b1;
        b1k[1023] = 1'b0;
        mext = {6'b0, m1k};
        @(posedge clk); #1; s1k = 1'b1;
        @(posedge clk); #1; s1k = 1'b0;
        for (int c = 1; c <= 96; c++) begin
            exp_we = ((c % 3) == 1) && (c <= 94);
            checks++;
            if (we1k !== exp_we) begin
                errors++;
                $display("FAIL wide wr_en c=%0d got %b want %b", c, we1k, exp_we);
            end
            if (exp_we) begin
                k    = (c - 1) / 3;
                prod = 1030'(k) * {6'b0, b1k};
                rem  = prod % mext;
                expd = rem[1023:0];
                checks++;
                if (wa1k !== 5'(k) || wd1k !== expd) begin
                    errors++;
                    $display("FAIL wide entry k=%0d got addr=%0d hi=%h lo=%h want addr=%0d hi=%h lo=%h",
                             k, wa1k, wd1k[1023:960], wd1k[63:0], k, expd[1023:960], expd[63:0]);
                end
            end
            checks++;
            if (done1k !== (c == 95) || busy1k !== (c <= 95)) begin
                errors++;
                $display("FAIL wide ctl c=%0d got done=%b busy=%b want done=%b busy=%b",
                         c, done1k, busy1k, (c == 95), (c <= 95));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_seq16();
        test_carry();
        test_busy_start();
        test_reset_abort();
        test_back_to_back();
        test_full_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 The parameter DATA_W SHALL default to 1024 and SHALL set the width of the residue and table entries.
REQ-002 The parameter IDX_W SHALL default to 5 and SHALL set the table index width; the table SHALL hold NUM = 2^IDX_W entries.
REQ-003 The port clk SHALL be an input of width 1 and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst_n SHALL be an input of width 1 and SHALL be an asynchronous, active-low reset.
REQ-005 The port start SHALL be an input of width 1 and SHALL request table generation.
REQ-006 The port base SHALL be an input of width DATA_W and SHALL carry the entry-1 residue; it SHALL be sampled with start.
REQ-007 The port modulus SHALL be an input of width DATA_W and SHALL carry the modulus M; it SHALL be sampled with start.
REQ-008 The port busy SHALL be an output of width 1 and SHALL be high while generation is in progress.
REQ-009 The port done SHALL be an output of width 1 and SHALL be a one-cycle completion pulse.
REQ-010 The port wr_en SHALL be an output of width 1 and SHALL be the table write strobe.
REQ-011 The port wr_addr SHALL be an output of width IDX_W and SHALL carry the table write index.
REQ-012 The port wr_data SHALL be an output of width DATA_W and SHALL carry the table write value.

Function
REQ-013 The block SHALL write entry[k] = (k * base_r) mod M for k = 0 to NUM-1, in ascending k order, through the write port; it is the generator for the 5-bit XPB lookup tables used in modular-square reduction.
REQ-014 On start sampled high in IDLE, the block SHALL latch M, set base_r = (base >= M) ? base - M : base, set acc = 0 and idx = 0, then move to WR. The precondition is base < 2M.
REQ-015 The FSM SHALL have the states IDLE, WR, ADD, RED and DONE, with these actions:
 - WR: wr_en=1, wr_addr=idx, wr_data=acc; if idx == NUM-1 -> DONE, else -> ADD.
 - ADD: sum = acc + base_r, computed DATA_W+1 bits wide with the carry kept; -> RED.
 - RED: acc = (sum >= M) ? sum - M : sum, truncated to DATA_W; idx = idx+1; -> WR.
 - DONE: done=1 for one cycle; -> IDLE.
REQ-016 If the start sample edge is cycle 0, entry k SHALL be written in cycle 1+3k (entry NUM-1 in cycle 3*NUM-2, which is 94 at the defaults), and done SHALL be high in cycle 3*NUM-1.
REQ-017 busy SHALL be high in every state except IDLE; it SHALL fall in the cycle after done.
REQ-018 start SHALL be ignored while busy is high; base and modulus changes after the start sample SHALL have no effect.
REQ-019 wr_en SHALL be high for exactly one cycle per entry and SHALL be low in all other cycles; wr_addr and wr_data SHALL be don't-care when wr_en is low.
REQ-020 The comparison sum >= M SHALL use the full DATA_W+1-bit sum, so a carry out of DATA_W bits SHALL force the subtraction.
REQ-021 If M == 0, the block SHALL still run to completion and write k*base_r mod 2^DATA_W; no error indication SHALL be given.
REQ-022 start held high continuously SHALL restart generation in the cycle after DONE returns to IDLE, with no gap write.

Reset
REQ-023 While rst_n is low, the state SHALL be IDLE and busy, done and wr_en SHALL be 0; wr_addr, wr_data, acc, idx, base_r and M SHALL be 0.
REQ-024 rst_n asserted mid-generation SHALL abort immediately: no further wr_en and no done pulse, with restart only through a new start after release.
REQ-025 start SHALL first be honoured on the first rising edge at which rst_n is high.

Verification
REQ-026 Basic sequence (DATA_W=16, IDX_W=5): M=97, base=40 -> writes (0,0),(1,40),(2,80),(3,23),(4,63),(5,6) and so on, with 32 writes, done in cycle 95 and busy low in cycle 96.
REQ-027 Carry path (DATA_W=8): M=251, base=250 -> entry1=250, entry2=249, entry3=248; entry2 exercises the 9th sum bit.
REQ-028 Base pre-reduction (DATA_W=16): M=97, base=100 -> base_r=3, entries 0,3,6,...,93 and then entry 31 = 93.
REQ-029 Control: start pulsed during busy -> ignored, exactly 32 writes and one done. rst_n low at cycle 40 -> no writes after that edge, no done, and all outputs 0.
REQ-030 Full width (defaults): random 1024-bit M with MSB set and base < M -> all 32 entries match the golden k*base mod M model, and write timing matches REQ-016.
